d_flip_flop: RTL and testbench
==============================

D_FLIP_FLOP -- requirements
Module: d_flip_flop

Interface
REQ-001 Parameter: WIDTH, default 1, number of independent flip-flop bits.
REQ-002 Parameter: RESET_VALUE, default all-zeros (WIDTH bits), value loaded into Q by reset.
REQ-003 Port: clk  input  1  single clock; all state changes except reset occur on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: D  input  WIDTH  data input, sampled at the rising edge of clk.
REQ-006 Port: Q  output  WIDTH  registered data output.
REQ-007 Port: Qbar  output  WIDTH  bitwise complement of Q.

Function
REQ-008 Rising-edge triggered: at each clk 0->1 transition with rst low, Q SHALL take the value D held just before the edge.
REQ-009 Latency: Q SHALL update within the same edge event, so the new value is visible before the next falling edge; there are no extra pipeline stages.
REQ-010 D changes while clk is steady (high or low) SHALL NOT affect Q; there is no transparency window at the outputs.
REQ-011 Falling clk edges SHALL NOT change Q.
REQ-012 Qbar SHALL equal ~Q at all times, including during and after reset; no cycle of skew.
REQ-013 Each bit SHALL behave independently; no cross-bit interaction for WIDTH > 1.
REQ-014 Before the first reset or first rising edge, Q and Qbar are X; the bench SHALL NOT check them in this state.
REQ-015 D changing at the exact instant of a rising edge is a setup violation; the captured value is undefined and is not a checked requirement.

Reset
REQ-016 On rst going high, Q SHALL become RESET_VALUE and Qbar ~RESET_VALUE immediately, with no clk edge needed.
REQ-017 While rst is high, rising clk edges SHALL be ignored, and Q SHALL hold RESET_VALUE.
REQ-018 On rst release, Q SHALL hold RESET_VALUE until the first rising edge after release; that edge SHALL capture D normally.
REQ-019 Reset asserted mid-operation SHALL override any pending capture.

Structure
REQ-020 Implementation is master-slave: master latch transparent while clk is low, slave latch transparent while clk is high; both latches have async reset forcing RESET_VALUE.
REQ-021 One sub-module, d_latch (ports: en, rst, d, q, qbar, parameterised by WIDTH and RESET_VALUE), is instantiated twice.
REQ-022 No shared package is needed; WIDTH and RESET_VALUE are the only constants.

Verification
REQ-023 Basic capture, WIDTH=1, clk period 20 (rising edges at 10, 30, 50, ...), rst low after an initial reset pulse. D=1 from t=0, 0 at t=20, 1 at t=55, 0 at t=100, 1 at t=140, 0 at t=160 -> required Q at edges t=10:1, t=30:0, t=70:1, t=90:1, t=110:0, t=130:0, t=150:1, t=170:0; Qbar always ~Q.
REQ-024 Hold between edges: toggle D 1->0->1 entirely while clk is high -> Q is unchanged until the next rising edge.
REQ-025 Async reset: with Q=1, assert rst mid-low-phase of clk -> Q=0 and Qbar=1 immediately; rising edges with D=1 while rst is high -> Q stays 0.
REQ-026 Reset release: deassert rst with D=1 -> Q stays 0 until the next rising edge, then Q=1.
REQ-027 Wide instance, WIDTH=8, RESET_VALUE=8'hA5: reset -> Q=8'hA5, Qbar=8'h5A; D=8'h3C at an edge -> Q=8'h3C, Qbar=8'hC3.

Source files
------------

// File: rtl/d_latch.sv
// Level-sensitive D latch with asynchronous active-high reset.
// It is used twice to form the master and slave halves of d_flip_flop.
module d_latch #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             en,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    logic [WIDTH-1:0] r_q;

    // Reset takes priority over the enable, so a transparent latch is still forced.
    always_latch begin
        if (rst)
            r_q <= RESET_VALUE;
        else if (en)
            r_q <= d;
    end

    assign q    = r_q;
    assign qbar = ~r_q;

endmodule

// File: rtl/d_flip_flop.sv
// Rising-edge D flip-flop built from two latches in a master-slave pair.
// Reset is asynchronous and active-high, and it forces both latches to RESET_VALUE.
module d_flip_flop #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar
);

    logic             w_clk_n;
    logic [WIDTH-1:0] w_master_q;
    logic [WIDTH-1:0] w_master_qbar_unused;

    assign w_clk_n = ~clk;

    // The master follows D while clk is low. It closes on the rising edge and
    // hands the value to the slave, which is transparent only while clk is high.
    d_latch #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_master (
        .en   (w_clk_n),
        .rst  (rst),
        .d    (D),
        .q    (w_master_q),
        .qbar (w_master_qbar_unused)
    );

    d_latch #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_slave (
        .en   (clk),
        .rst  (rst),
        .d    (w_master_q),
        .q    (Q),
        .qbar (Qbar)
    );

endmodule

// File: tb/tb_d_flip_flop.sv
// Scoreboard bench for d_flip_flop: a 1-bit instance and an 8-bit instance with reset value 8'hA5.
// Stimulus pushes expected Q values, and a monitor pops them and checks both Q and Qbar.
module tb_d_flip_flop;

    localparam logic [7:0] RV8 = 8'hA5;

    typedef struct {
        string      name;
        bit         wide;
        logic [7:0] q;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rst8;
    logic [0:0] D;
    logic [0:0] Q;
    logic [0:0] Qbar;
    logic [7:0] D8;
    logic [7:0] Q8;
    logic [7:0] Qbar8;

    exp_t sb[$];
    event chk_ev;
    int   n_vec  = 0;
    int   n_miss = 0;
    logic [0:0] m_q;
    logic [7:0] m_q8;

    d_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .D    (D),
        .Q    (Q),
        .Qbar (Qbar)
    );

    d_flip_flop #(.WIDTH(8), .RESET_VALUE(RV8)) u_dut8 (
        .clk  (clk),
        .rst  (rst8),
        .D    (D8),
        .Q    (Q8),
        .Qbar (Qbar8)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic push_exp(input string name, input bit wide, input logic [7:0] q);
        exp_t e;
        e.name = name;
        e.wide = wide;
        e.q    = q;
        sb.push_back(e);
        -> chk_ev;
    endtask

    task automatic at_t(input int t);
        #(t - int'($time));
    endtask

    // Monitor: drains the scoreboard one time unit after each stimulus request.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (e.wide) begin
                    if (Q8 !== e.q || Qbar8 !== ~e.q) begin
                        n_miss++;
                        $display("FAIL %s t=%0t: Q=%h Qbar=%h, required Q=%h Qbar=%h",
                                 e.name, $time, Q8, Qbar8, e.q, ~e.q);
                    end
                end else begin
                    if (Q[0] !== e.q[0] || Qbar[0] !== ~e.q[0]) begin
                        n_miss++;
                        $display("FAIL %s t=%0t: Q=%b Qbar=%b, required Q=%b Qbar=%b",
                                 e.name, $time, Q[0], Qbar[0], e.q[0], ~e.q[0]);
                    end
                end
            end
        end
    end

    initial begin
        // Directed phase: fixed capture schedule, hold behaviour, and reset behaviour.
        rst = 1'b1; rst8 = 1'b1; D = 1'b1; D8 = 8'h3C;
        at_t(3);   push_exp("rst_q", 0, 8'h00); push_exp("rst_w8", 1, RV8);
        at_t(5);   rst = 1'b0; rst8 = 1'b0;
        at_t(7);   push_exp("rel_hold", 0, 8'h00); push_exp("rel_hold_w8", 1, RV8);
        at_t(10);  push_exp("edge10", 0, 8'h01); push_exp("edge10_w8", 1, 8'h3C);
        at_t(20);  D = 1'b0;
        at_t(25);  push_exp("fall_hold", 0, 8'h01);
        at_t(30);  push_exp("edge30", 0, 8'h00);
        at_t(50);  push_exp("edge50", 0, 8'h00);
        at_t(55);  D = 1'b1;
        at_t(70);  push_exp("edge70", 0, 8'h01);
        at_t(90);  push_exp("edge90", 0, 8'h01);
        at_t(100); D = 1'b0;
        at_t(110); push_exp("edge110", 0, 8'h00);
        at_t(130); push_exp("edge130", 0, 8'h00);
        at_t(140); D = 1'b1;
        at_t(150); push_exp("edge150", 0, 8'h01);
        at_t(160); D = 1'b0;
        at_t(170); push_exp("edge170", 0, 8'h00);
        at_t(180); D = 1'b1;
        at_t(190); push_exp("edge190", 0, 8'h01);
        at_t(192); D = 1'b0;
        at_t(194); D = 1'b1;
        at_t(196); D = 1'b0;
        at_t(198); push_exp("high_hold", 0, 8'h01);
        at_t(210); push_exp("edge210", 0, 8'h00);
        at_t(215); D = 1'b1;
        at_t(230); push_exp("edge230", 0, 8'h01);
        at_t(244); rst = 1'b1; rst8 = 1'b1;
                   push_exp("arst_imm", 0, 8'h00); push_exp("arst_imm_w8", 1, RV8);
        at_t(250); push_exp("arst_edge250", 0, 8'h00); push_exp("arst_edge_w8", 1, RV8);
        at_t(270); push_exp("arst_edge270", 0, 8'h00);
        at_t(275); rst = 1'b0; rst8 = 1'b0;
        at_t(277); push_exp("rel_277", 0, 8'h00);
        at_t(280); D8 = 8'h5F;
        at_t(285); push_exp("rel_285", 0, 8'h00); push_exp("rel_285_w8", 1, RV8);
        at_t(290); push_exp("rel_edge290", 0, 8'h01); push_exp("rel_edge_w8", 1, 8'h5F);
        m_q = 1'b1; m_q8 = 8'h5F;

        // Random phase: each iteration starts on a falling edge.
        at_t(300);
        for (int i = 0; i < 200; i++) begin
            #2;
            D = 1'($urandom); D8 = 8'($urandom);
            #2;
            if (!rst && $urandom_range(0, 7) == 0) begin
                rst = 1'b1; rst8 = 1'b1;
                m_q = 1'b0; m_q8 = RV8;
                push_exp("rnd_arst", 0, {7'b0, m_q}); push_exp("rnd_arst_w8", 1, m_q8);
            end
            #6;
            if (!rst) begin
                m_q = D; m_q8 = D8;
            end
            push_exp("rnd_edge", 0, {7'b0, m_q}); push_exp("rnd_edge_w8", 1, m_q8);
            #3;
            if (rst && $urandom_range(0, 1) == 1) begin
                rst = 1'b0; rst8 = 1'b0;
            end
            #2;
            push_exp("rnd_hold", 0, {7'b0, m_q}); push_exp("rnd_hold_w8", 1, m_q8);
            #2;
            D = 1'($urandom); D8 = 8'($urandom);
            #3;
        end

        #5;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
